apb_master_arbiter: RTL
=======================

# apb_master_arbiter

APB master-side controller that shares one APB slave port (e.g. the team's 32×32 APB memory slave) among NREQ local requesters. It arbitrates round-robin, sequences the APB IDLE→SETUP→ACCESS protocol, waits for `P_ready`, and returns read data and error status to the winning requester. It sits between the internal request fabric and the APB slave.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 16: maximum ACCESS-phase wait cycles. Used only when the timeout feature is compiled in.

Ports (the reset is asynchronous and active-low, named as in the codebase):
- `P_clk` in 1: clock, rising edge.
- `P_rst` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester request.
- `req_write` in NREQ: per-requester direction, 1 = write.
- `req_addr` in NREQ*AW: packed addresses; requester i is at [i*AW +: AW].
- `req_wdata` in NREQ*DW: packed write data; requester i is at [i*DW +: DW].
- `req_gnt` out NREQ: one-hot owner, high during SETUP and ACCESS.
- `rsp_valid` out NREQ: one-hot, one-cycle completion pulse.
- `rsp_rdata` out DW: read data of the last completion.
- `rsp_slverr` out 1: error flag of the last completion.
- `P_addr` out AW, `P_wdata` out DW, `P_write` out 1, `P_selx` out 1, `P_enable` out 1: APB request, all registered.
- `P_ready` in 1, `P_rdata` in DW, `P_slverr` in 1: APB response.

## Operation
- **Reset values.** Every output is 0 on reset. The state is IDLE and the round-robin pointer is 0, so requester 0 has the highest priority.
- **State encoding:** IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10. The unused encoding 2'b11 returns to IDLE.
- **Arbitration.** It runs in IDLE, and in ACCESS on the cycle `P_ready` is sampled high.
  - Search order starts at (last owner + 1) mod NREQ.
  - The just-completed owner is masked for that arbitration, and also in IDLE while its `rsp_valid` is high.
- **Requester contract.** Hold `req_valid` and the payload stable until `rsp_valid` is seen; deassert `req_valid` in that same cycle or earlier. The payload is latched at grant, so changes after grant are ignored.
- **IDLE → SETUP.** When any unmasked request is present, latch the winner's addr/wdata/write, then drive `P_selx`=1, `P_enable`=0 and `req_gnt`=winner.
- **SETUP → ACCESS.** Unconditional after 1 cycle; `P_enable`=1.
- **ACCESS.** Hold all APB outputs stable until `P_ready`=1. On that sample:
  - Capture `P_slverr`.
  - Capture `P_rdata` for reads; for writes, load 0 into `rsp_rdata`.
  - Pulse `rsp_valid[owner]` on the next cycle.
  - Go to SETUP if another unmasked request exists (back-to-back, `P_selx` stays high), else go to IDLE with `P_selx`=`P_enable`=0.
- **Held response.** `rsp_rdata` and `rsp_slverr` hold until the next completion.
- **Reset mid-transfer.** The bus drops immediately (asynchronous). The transfer is lost and no `rsp_valid` is issued.
- **Simultaneous requests.** Exactly one grant is issued. With all NREQ requesting continuously, each requester is served once per NREQ transfers.

## Timing
- Request seen in IDLE at edge 0 → SETUP cycle 1 → ACCESS cycle 2.
  - With zero wait states (`P_ready`=1 in cycle 2), `rsp_valid` is high in cycle 3.
  - Each wait state adds 1 cycle.
- Throughput: 2 cycles per transfer back-to-back, 3 cycles per transfer if returning through IDLE.
- `rsp_valid` is never high for more than 1 cycle per transfer.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - An ACCESS-cycle counter counts the cycles in which `P_ready`=0.
  - When the counter reaches `TIMEOUT` with `P_ready` still 0, the transfer is terminated: `rsp_valid[owner]` pulses with `rsp_slverr`=1 and `rsp_rdata`=0, and the next state follows the normal completion rule.
  - The counter clears on entry to SETUP.
- `APB_ARB_TIMEOUT_EN` undefined: no counter, ACCESS waits indefinitely, and `TIMEOUT` is ignored.

## Structure
- `apb_pkg` holds:
  - the state enum with the encodings above;
  - default AW/DW constants;
  - a `clog2`-based pointer-width helper.
- Sub-module `apb_rr_arbiter`: combinational round-robin picker.
  - Inputs: request vector, mask, pointer.
  - Outputs: one-hot grant and any-valid.
  - The FSM, datapath registers and pointer update stay in `apb_master_arbiter`.

## Test plan
- **Single write, zero wait.** Requester 1 writes addr 0x04 / data 0xDEADBEEF. Required: `P_selx`=1 in cycle 1; `P_enable`=1 and `P_write`=1 in cycle 2; `rsp_valid`=4'b0010 and `rsp_slverr`=0 in cycle 3.
- **Read with 3 wait states.** Slave returns 0x12345678. Required: `P_addr`/`P_enable` stable for 4 ACCESS cycles, then `rsp_rdata`=0x12345678 with `rsp_valid` pulsed once.
- **All 4 requesting continuously.** Required: grant order 0,1,2,3,0; back-to-back SETUP with no IDLE cycle; 2 cycles per transfer.
- **Reset mid-ACCESS.** Assert `P_rst`=0 in ACCESS. Required: all outputs 0 immediately; no `rsp_valid`; next grant goes to requester 0.
- **Timeout.** With `APB_ARB_TIMEOUT_EN`, TIMEOUT=16 and `P_ready` held at 0: `rsp_slverr`=1 and `rsp_rdata`=0 after 16 ACCESS cycles. Without the macro, the bus stays in ACCESS.
- **Slave error.** `P_slverr`=1 with `P_ready`. Required: `rsp_slverr`=1 for that completion and 0 for the next clean transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master arbiter.
// State encodings, default widths and pointer-width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Request fabric and APB bus bundle for apb_master_arbiter.
// master = arbiter view, slave = requesters plus APB slave view.
interface apb_master_arbiter_if
    import apb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = APB_AW,
    parameter int DW   = APB_DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_slverr;

    logic [AW-1:0]      P_addr;
    logic [DW-1:0]      P_wdata;
    logic               P_write;
    logic               P_selx;
    logic               P_enable;
    logic               P_ready;
    logic [DW-1:0]      P_rdata;
    logic               P_slverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  P_ready, P_rdata, P_slverr,
        output req_gnt, rsp_valid, rsp_rdata, rsp_slverr,
        output P_addr, P_wdata, P_write, P_selx, P_enable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output P_ready, P_rdata, P_slverr,
        input  req_gnt, rsp_valid, rsp_rdata, rsp_slverr,
        input  P_addr, P_wdata, P_write, P_selx, P_enable
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: search starts at ptr and wraps,
// masked requesters are skipped.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any
);

    logic [NREQ-1:0] eff;
    logic            found;
    int              idx;

    assign eff = req & ~mask;
    assign any = |eff;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && eff[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sharing one slave port among NREQ requesters.
// Optional ACCESS watchdog: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 16
) (
    input  logic                 P_clk,
    input  logic                 P_rst,
    apb_master_arbiter_if.master bus
);

    localparam int PW = ptr_w(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_cfg_err
        $error("apb_master_arbiter: unsupported NREQ or TIMEOUT");
    end

    apb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            write_q, write_d;
    logic            selx_q, selx_d;
    logic            enable_q, enable_d;
    logic [NREQ-1:0] rspv_q, rspv_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            slverr_q, slverr_d;

    logic [NREQ-1:0] arb_mask, arb_gnt;
    logic            arb_any;
    logic [PW-1:0]   win_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_write;
    logic            done, timeout, start;

    // The finishing owner may not win twice in a row, nor re-win
    // while its completion pulse is still visible.
    assign arb_mask = (state_q == ST_IDLE)   ? rspv_q :
                      (state_q == ST_ACCESS) ? gnt_q  : '0;

    apb_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req  (bus.req_valid),
        .mask (arb_mask),
        .ptr  (ptr_q),
        .gnt  (arb_gnt),
        .any  (arb_any)
    );

    always_comb begin
        win_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                win_idx   = PW'(i);
                sel_addr  = bus.req_addr[i*AW +: AW];
                sel_wdata = bus.req_wdata[i*DW +: DW];
                sel_write = bus.req_write[i];
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == ST_ACCESS) && !bus.P_ready &&
                     (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ST_SETUP)
            cnt_d = '0;
        else if (state_q == ST_ACCESS && !bus.P_ready)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign done = (state_q == ST_ACCESS) && (bus.P_ready || timeout);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        selx_d   = selx_q;
        enable_d = enable_q;
        rspv_d   = '0;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        start    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                start = arb_any;
            end
            ST_SETUP: begin
                state_d  = ST_ACCESS;
                enable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (done) begin
                    rspv_d   = gnt_q;
                    rdata_d  = (write_q || timeout) ? '0 : bus.P_rdata;
                    slverr_d = timeout ? 1'b1 : bus.P_slverr;
                    start    = arb_any;
                    if (!arb_any) begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        selx_d   = 1'b0;
                        enable_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                selx_d   = 1'b0;
                enable_d = 1'b0;
            end
        endcase

        if (start) begin
            state_d  = ST_SETUP;
            gnt_d    = arb_gnt;
            addr_d   = sel_addr;
            wdata_d  = sel_wdata;
            write_d  = sel_write;
            selx_d   = 1'b1;
            enable_d = 1'b0;
            ptr_d    = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            selx_q   <= 1'b0;
            enable_q <= 1'b0;
            rspv_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            selx_q   <= selx_d;
            enable_q <= enable_d;
            rspv_q   <= rspv_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    assign bus.req_gnt    = gnt_q;
    assign bus.rsp_valid  = rspv_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_slverr = slverr_q;
    assign bus.P_addr     = addr_q;
    assign bus.P_wdata    = wdata_q;
    assign bus.P_write    = write_q;
    assign bus.P_selx     = selx_q;
    assign bus.P_enable   = enable_q;

endmodule
